pair_selector: RTL and testbench
================================

Name: pair_selector

Overview:
- Front end of the memory-game datapath: the producing side of the match/selected interface consumed by the flip-back logic.
- Accepts card picks from the input controller and latches the first and second picks.
- Holds both cards face-up for a configurable reveal time, then compares their symbols.
- Drives selected1/selected2/par plus a one-cycle result strobe, and tracks per-card matched flags.

Parameters:
- N_CARDS, 16, number of board positions; must be even and ≤ 255.
- SYM_W, 4, width of a card symbol.
- SHOW_CYCLES, 50_000_000, clock cycles both cards stay revealed before the result is issued; must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- board_sym  in  N_CARDS*SYM_W  flat symbol table; card i occupies bits [i*SYM_W +: SYM_W]. Must be stable during a turn.
- pick_valid  in  1  a pick is offered.
- pick_idx  in  8  card index offered.
- pick_ready  out  1  the block can accept a pick this cycle.
- selected1  out  8  first card of the turn; 8'hFF means none.
- selected2  out  8  second card of the turn; 8'hFF means none.
- par  out  1  compare result of the last completed turn (1 = match).
- res_valid  out  1  one-cycle strobe; par, selected1 and selected2 are valid for the flip-back logic.
- matched  out  N_CARDS  bit i set when card i has been paired.
- game_over  out  1  all cards are matched.

Behaviour:
- Reset values: selected1 = selected2 = 8'hFF, par = 0, res_valid = 0, matched = 0, game_over = 0, state = WAIT_FIRST, timer = 0. Reset is asynchronous, so asserting it mid-turn aborts immediately.
- Pick acceptance: a pick is accepted when pick_valid && pick_ready.
- Illegal picks: a pick with pick_idx ≥ N_CARDS, or matched[pick_idx] = 1, is ignored. It is not accepted and the state is unchanged.
- pick_ready = 1 only in WAIT_FIRST and WAIT_SECOND.

State machine:
- WAIT_FIRST: on a legal pick, selected1 ← pick_idx and selected2 ← 8'hFF; go to WAIT_SECOND. selected1 is visible the cycle after the pick is accepted.
- WAIT_SECOND: on a legal pick with pick_idx ≠ selected1, selected2 ← pick_idx, timer ← 0, go to SHOW. A re-pick of selected1 is ignored.
- SHOW: timer increments every cycle. When timer = SHOW_CYCLES-1, go to RESULT and latch par ← (sym[selected1] == sym[selected2]).
- RESULT (one cycle): res_valid = 1.
  - If par = 1, set matched[selected1] and matched[selected2].
  - Next state is DONE if the updated matched vector is all ones; otherwise WAIT_FIRST.
  - selected1 and selected2 keep their values during this cycle and are cleared to 8'hFF on exit to WAIT_FIRST.
- DONE: game_over = 1, pick_ready = 0. The block stays in DONE until reset.

Timing and widths:
- Latency from accepting the second pick to res_valid is exactly SHOW_CYCLES + 1 cycles.
- The timer is $clog2(SHOW_CYCLES+1) bits wide and never wraps, because it is reloaded on SHOW entry.
- par holds its value until the next RESULT; it is not cleared on a new turn.

Decomposition:
- Shared package game_pkg holds:
  - typedef card_idx_t (logic [7:0]);
  - constant NO_CARD = 8'hFF;
  - state enum sel_state_t {WAIT_FIRST, WAIT_SECOND, SHOW, RESULT, DONE};
  - the N_CARDS default, which the flip-back logic also uses.
- One natural sub-module, reveal_timer: a load/count/expire counter with parameter SHOW_CYCLES, inputs start and clk/rst_n, output expired.
- The symbol mux and compare stay inline.

Test Plan (N_CARDS=16, SYM_W=4, SHOW_CYCLES=4, board_sym with cards 3 and 6 = symbol 5, all others distinct):
- Reset mid-SHOW (after picks 3 and 6) -> next cycle: selected1 = selected2 = 8'hFF, par = 0, matched = 0, pick_ready = 1.
- Pick 3 then pick 6 -> res_valid pulses exactly 5 cycles after pick 6 is accepted, with par = 1, selected1 = 3, selected2 = 6; afterwards matched = 16'h0048.
- Pick 1 then pick 2 (different symbols) -> res_valid with par = 0; matched unchanged; selected1 and selected2 return to 8'hFF.
- Pick 3 after it is matched, pick index 20, and re-pick of the first card -> each is ignored; state unchanged, no res_valid.
- pick_valid held high during SHOW -> pick_ready = 0 and no pick is accepted until after RESULT.
- Match all 8 pairs -> game_over = 1 the cycle after the final RESULT; pick_ready stays 0; matched = 16'hFFFF.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the memory-game datapath.
// Card indices, the empty-slot marker and the pair selector states.
package game_pkg;

  typedef logic [7:0] card_idx_t;

  localparam card_idx_t NO_CARD = 8'hFF;
  localparam int N_CARDS_DEF = 16;

  typedef enum logic [2:0] {
    WAIT_FIRST  = 3'd0,
    WAIT_SECOND = 3'd1,
    SHOW        = 3'd2,
    RESULT      = 3'd3,
    DONE        = 3'd4
  } sel_state_t;

endpackage

// File: rtl/pair_selector_if.sv
// Pick handshake from the input controller and the
// turn result consumed by the flip-back logic.
interface pair_selector_if;
  import game_pkg::*;

  logic      pick_valid;
  card_idx_t pick_idx;
  logic      pick_ready;
  card_idx_t selected1;
  card_idx_t selected2;
  logic      par;
  logic      res_valid;

  modport master (
    output pick_valid, pick_idx,
    input  pick_ready, selected1, selected2,
    input  par, res_valid
  );

  modport slave (
    input  pick_valid, pick_idx,
    output pick_ready, selected1, selected2,
    output par, res_valid
  );

endinterface

// File: rtl/pair_selector_reveal_timer.sv
// Reveal timer: start reloads and arms it, expired marks
// the last revealed cycle, after which it idles.
module reveal_timer #(
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expired
);

  localparam int TW = $clog2(SHOW_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(SHOW_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          run;

  assign expired = run && (timer == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      run   <= 1'b0;
    end else if (start) begin
      timer <= '0;
      run   <= 1'b1;
    end else if (expired) begin
      run   <= 1'b0;
    end else if (run) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/pair_selector.sv
// Latches two card picks, reveals them for SHOW_CYCLES,
// then compares symbols and tracks matched cards.
module pair_selector
  import game_pkg::*;
#(
  parameter int N_CARDS     = N_CARDS_DEF,
  parameter int SYM_W       = 4,
  parameter int SHOW_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CARDS*SYM_W-1:0] board_sym,
  pair_selector_if.slave           bus,
  output logic [N_CARDS-1:0]       matched,
  output logic                     game_over
);

  sel_state_t         state;
  card_idx_t          sel1;
  card_idx_t          sel2;
  logic               par_q;
  logic [N_CARDS-1:0] matched_q;
  logic [N_CARDS-1:0] matched_nxt;
  logic [SYM_W-1:0]   sym1;
  logic [SYM_W-1:0]   sym2;
  logic               hit;
  logic               in_range;
  logic               legal;
  logic               accept;
  logic               second_ok;
  logic               expired;

  // Index compares instead of direct indexing keep
  // out-of-range picks harmless.
  always_comb begin
    hit         = 1'b0;
    sym1        = '0;
    sym2        = '0;
    matched_nxt = matched_q;
    for (int i = 0; i < N_CARDS; i++) begin
      if (bus.pick_idx == card_idx_t'(i))
        hit = matched_q[i];
      if (sel1 == card_idx_t'(i))
        sym1 = board_sym[i*SYM_W +: SYM_W];
      if (sel2 == card_idx_t'(i))
        sym2 = board_sym[i*SYM_W +: SYM_W];
      if (par_q && (sel1 == card_idx_t'(i)))
        matched_nxt[i] = 1'b1;
      if (par_q && (sel2 == card_idx_t'(i)))
        matched_nxt[i] = 1'b1;
    end
  end

  assign in_range  = bus.pick_idx < card_idx_t'(N_CARDS);
  assign legal     = in_range && !hit;
  assign accept    = bus.pick_valid && bus.pick_ready
                  && legal;
  assign second_ok = accept && (state == WAIT_SECOND)
                  && (bus.pick_idx != sel1);

  reveal_timer #(
    .SHOW_CYCLES(SHOW_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (second_ok),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_FIRST;
      sel1      <= NO_CARD;
      sel2      <= NO_CARD;
      par_q     <= 1'b0;
      matched_q <= '0;
    end else begin
      unique case (state)
        WAIT_FIRST: begin
          if (accept) begin
            sel1  <= bus.pick_idx;
            sel2  <= NO_CARD;
            state <= WAIT_SECOND;
          end
        end
        WAIT_SECOND: begin
          if (second_ok) begin
            sel2  <= bus.pick_idx;
            state <= SHOW;
          end
        end
        SHOW: begin
          if (expired) begin
            par_q <= (sym1 == sym2);
            state <= RESULT;
          end
        end
        RESULT: begin
          matched_q <= matched_nxt;
          if (&matched_nxt) begin
            state <= DONE;
          end else begin
            sel1  <= NO_CARD;
            sel2  <= NO_CARD;
            state <= WAIT_FIRST;
          end
        end
        DONE: begin
        end
        default: state <= WAIT_FIRST;
      endcase
    end
  end

  assign bus.pick_ready = (state == WAIT_FIRST)
                       || (state == WAIT_SECOND);
  assign bus.selected1  = sel1;
  assign bus.selected2  = sel2;
  assign bus.par        = par_q;
  assign bus.res_valid  = (state == RESULT);
  assign matched        = matched_q;
  assign game_over      = (state == DONE);

endmodule

// File: tb/tb_pair_selector.sv
// Scoreboard bench for pair_selector: expected turn results
// are queued at the second pick and popped at res_valid.
module tb_pair_selector;
  import game_pkg::*;

  localparam int NC = 16;
  localparam int SW = 4;
  localparam int SC = 4;

  logic              clk;
  logic              rst_n;
  logic [NC*SW-1:0]  board_sym;
  logic [NC-1:0]     matched;
  logic              game_over;

  pair_selector_if bus ();

  pair_selector #(
    .N_CARDS    (NC),
    .SYM_W      (SW),
    .SHOW_CYCLES(SC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .board_sym(board_sym),
    .bus      (bus),
    .matched  (matched),
    .game_over(game_over)
  );

  typedef struct packed {
    logic      par;
    card_idx_t s1;
    card_idx_t s2;
  } exp_t;

  exp_t          sb[$];
  logic [NC-1:0] exp_matched;
  int            n_cmp = 0;
  int            n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] sym_of(card_idx_t i);
    return board_sym[int'(i)*SW +: SW];
  endfunction

  task automatic load_distinct();
    for (int i = 0; i < NC; i++)
      board_sym[i*SW +: SW] = SW'(i);
    board_sym[3*SW +: SW] = 4'd5;
    board_sym[5*SW +: SW] = 4'd3;
    board_sym[6*SW +: SW] = 4'd5;
  endtask

  task automatic load_pairs();
    for (int i = 0; i < NC; i++)
      board_sym[i*SW +: SW] = SW'(i / 2);
  endtask

  task automatic pick(input card_idx_t idx);
    @(negedge clk);
    bus.pick_valid = 1'b1;
    bus.pick_idx   = idx;
    @(negedge clk);
    bus.pick_valid = 1'b0;
  endtask

  task automatic finish_turn(input card_idx_t a,
                             input card_idx_t b);
    exp_t e;
    int   lat;
    e.par = (sym_of(a) == sym_of(b));
    e.s1  = a;
    e.s2  = b;
    @(negedge clk);
    bus.pick_valid = 1'b1;
    bus.pick_idx   = b;
    sb.push_back(e);
    if (e.par) begin
      exp_matched[int'(a)] = 1'b1;
      exp_matched[int'(b)] = 1'b1;
    end
    @(negedge clk);
    bus.pick_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (bus.res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL res_timeout %0d/%0d got %b want 1",
               a, b, bus.res_valid);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      n_cmp++;
      if (lat != SC + 1) begin
        n_bad++;
        $display("FAIL latency got %0d want %0d",
                 lat, SC + 1);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty got 0 want >0");
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.par !== e.par) begin
          n_bad++;
          $display("FAIL par got %b want %b",
                   bus.par, e.par);
        end
        n_cmp++;
        if (bus.selected1 !== e.s1) begin
          n_bad++;
          $display("FAIL res_sel1 got %h want %h",
                   bus.selected1, e.s1);
        end
        n_cmp++;
        if (bus.selected2 !== e.s2) begin
          n_bad++;
          $display("FAIL res_sel2 got %h want %h",
                   bus.selected2, e.s2);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL res_one_cycle got %b want 0",
               bus.res_valid);
    end
    n_cmp++;
    if (matched !== exp_matched) begin
      n_bad++;
      $display("FAIL matched got %h want %h",
               matched, exp_matched);
    end
    n_cmp++;
    if (&exp_matched) begin
      if (game_over !== 1'b1) begin
        n_bad++;
        $display("FAIL game_over got %b want 1", game_over);
      end
    end else begin
      if (bus.selected1 !== NO_CARD
          || bus.selected2 !== NO_CARD) begin
        n_bad++;
        $display("FAIL sel_clear got %h/%h want ff/ff",
                 bus.selected1, bus.selected2);
      end
    end
  endtask

  task automatic do_turn(input card_idx_t a,
                         input card_idx_t b);
    pick(a);
    n_cmp++;
    if (bus.selected1 !== a) begin
      n_bad++;
      $display("FAIL first_pick got %h want %h",
               bus.selected1, a);
    end
    finish_turn(a, b);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.pick_valid = 1'b0;
    bus.pick_idx   = '0;
    load_distinct();
    exp_matched = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.selected1 !== NO_CARD
        || bus.selected2 !== NO_CARD) begin
      n_bad++;
      $display("FAIL rst_sel got %h/%h want ff/ff",
               bus.selected1, bus.selected2);
    end
    n_cmp++;
    if ({bus.par, bus.res_valid, game_over} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flags got %b%b%b want 000",
               bus.par, bus.res_valid, game_over);
    end
    n_cmp++;
    if (matched !== '0 || bus.pick_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_match_ready got %h/%b want 0/1",
               matched, bus.pick_ready);
    end
    pick(3);
    pick(6);
    @(negedge clk);
    n_cmp++;
    if (bus.pick_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL show_ready got %b want 0",
               bus.pick_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.selected1 !== NO_CARD
        || bus.selected2 !== NO_CARD) begin
      n_bad++;
      $display("FAIL async_rst got %h/%h want ff/ff",
               bus.selected1, bus.selected2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.pick_ready !== 1'b1 || bus.par !== 1'b0
        || matched !== '0) begin
      n_bad++;
      $display("FAIL post_rst got %b/%b/%h want 1/0/0",
               bus.pick_ready, bus.par, matched);
    end
  endtask

  task automatic test_match();
    do_turn(3, 6);
    n_cmp++;
    if (matched !== 16'h0048) begin
      n_bad++;
      $display("FAIL match_vec got %h want 0048", matched);
    end
  endtask

  task automatic test_mismatch();
    do_turn(1, 2);
    n_cmp++;
    if (matched !== 16'h0048) begin
      n_bad++;
      $display("FAIL mismatch_vec got %h want 0048", matched);
    end
  endtask

  task automatic test_illegal();
    logic seen;
    card_idx_t bad[2];
    bad[0] = 8'd3;
    bad[1] = 8'd20;
    foreach (bad[k]) begin
      pick(bad[k]);
      n_cmp++;
      if (bus.selected1 !== NO_CARD
          || bus.pick_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal_%0d got %h/%b want ff/1",
                 bad[k], bus.selected1, bus.pick_ready);
      end
    end
    pick(1);
    pick(1);
    n_cmp++;
    if (bus.selected2 !== NO_CARD
        || bus.pick_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL repick got %h/%b want ff/1",
               bus.selected2, bus.pick_ready);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_res got %b want 0", seen);
    end
    finish_turn(1, 2);
  endtask

  task automatic test_hold_valid();
    exp_t e;
    int   lat;
    logic busy;
    pick(0);
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 8'd7;
    e.par = (sym_of(8'd0) == sym_of(8'd7));
    e.s1  = 8'd0;
    e.s2  = 8'd7;
    sb.push_back(e);
    lat  = 0;
    busy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.pick_ready) busy = 1'b1;
    end while (!bus.res_valid && lat < 20);
    n_cmp++;
    if (lat != SC + 1) begin
      n_bad++;
      $display("FAIL hold_latency got %0d want %0d",
               lat, SC + 1);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_ready got %b want 0", busy);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({bus.par, bus.selected1, bus.selected2} !== e) begin
      n_bad++;
      $display("FAIL hold_res got %b/%h/%h want %b/%h/%h",
               bus.par, bus.selected1, bus.selected2,
               e.par, e.s1, e.s2);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.selected1 !== NO_CARD
        || bus.pick_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_exit got %h/%b want ff/1",
               bus.selected1, bus.pick_ready);
    end
    @(negedge clk);
    bus.pick_valid = 1'b0;
    n_cmp++;
    if (bus.selected1 !== 8'd7) begin
      n_bad++;
      $display("FAIL hold_repick got %h want 07",
               bus.selected1);
    end
    finish_turn(7, 8);
  endtask

  task automatic test_game_over();
    logic seen;
    rst_n = 1'b0;
    load_pairs();
    exp_matched = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NC / 2; k++)
      do_turn(card_idx_t'(2 * k), card_idx_t'(2 * k + 1));
    n_cmp++;
    if (matched !== 16'hFFFF || bus.pick_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL done_state got %h/%b want ffff/0",
               matched, bus.pick_ready);
    end
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 8'd0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.res_valid || bus.pick_ready || !game_over)
        seen = 1'b1;
    end
    bus.pick_valid = 1'b0;
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL done_sticky got %b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_illegal();
    test_hold_valid();
    test_game_over();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
